// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_types_pkg
//  Description : Shared CPU datapath types: next-PC select, fetch FSM state,
//                default sequential fetch step and a word-alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // EX/MEM next-PC source
    typedef enum logic [1:0] {
        PC_NPC = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pcselect_t;

    // Fetch stage state; HALTED is left only through reset
    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] c_PC_STEP_DEFAULT = 32'd4;

    // Instruction addresses are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fetch_stage_if
//  Description : Bundle of all fetch_stage signals with a design-side (fs)
//                and an environment-side (tb) view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if
    import cpu_types_pkg::*;
(
    input  logic CLK
);
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        pc_enable;
    logic        ifid_enable;
    logic        ifid_flush;
    pcselect_t   pc_select;
    logic [31:0] br_addr;
    logic [31:0] j_addr;
    logic [31:0] jr_addr;
    logic        halt;
    logic [31:0] ifid_imemload;
    logic [31:0] ifid_npc;
    logic        ifid_valid;

    modport fs (
        input  CLK, nRST, ihit, imemload, pc_enable, ifid_enable, ifid_flush,
               pc_select, br_addr, j_addr, jr_addr, halt,
        output iREN, imemaddr, ifid_imemload, ifid_npc, ifid_valid
    );

    modport tb (
        input  CLK, iREN, imemaddr, ifid_imemload, ifid_npc, ifid_valid,
        output nRST, ihit, imemload, pc_enable, ifid_enable, ifid_flush,
               pc_select, br_addr, j_addr, jr_addr, halt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid
//  Description : One-entry skid buffer holding a fetched word and its PC+step
//                while the IF/ID latch is stalled. Used only when
//                FETCH_SKID_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_capture,
    input  logic        i_release,
    input  logic        i_clear,
    input  logic [31:0] i_data,
    input  logic [31:0] i_npc,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic [31:0] o_npc
);
    logic        r_valid;
    logic [31:0] r_data;
    logic [31:0] r_npc;

    // Entry: clear (flush/redirect) beats release, release beats capture
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_data  <= 32'h0;
            r_npc   <= 32'h0;
        end else if (i_clear || (i_release && r_valid)) begin
            r_valid <= 1'b0;
        end else if (i_capture && !r_valid) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_npc   <= i_npc;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_npc   = r_npc;
endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage and IF/ID pipeline latch. Owns the
//                PC, issues instruction reads and selects the next PC from
//                EX/MEM redirects under hazard-unit control.
//  Config      : FETCH_SKID_EN - adds a one-entry skid buffer that absorbs a
//                hit arriving while IF/ID is stalled and drops iREN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = c_PC_STEP_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        pc_enable,
    input  logic        ifid_enable,
    input  logic        ifid_flush,
    input  pcselect_t   pc_select,
    input  logic [31:0] br_addr,
    input  logic [31:0] j_addr,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    output logic [31:0] ifid_imemload,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid
);
    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_run;          // 0 until the first edge after reset release
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_sel;
    logic [31:0]  w_npc;
    logic         w_frozen;
    logic         w_redirect;
    logic         w_fetch_act;
    logic         w_skid_valid;
    logic [31:0]  w_ld_ins;
    logic [31:0]  w_ld_npc;
    logic         w_ld_valid;
    logic [31:0]  r_ifid_ins;
    logic [31:0]  r_ifid_npc;
    logic         r_ifid_valid;

    assign w_npc       = r_pc + PC_STEP;
    assign w_frozen    = halt || (r_state == HALTED);
    assign w_redirect  = pc_enable && (pc_select != PC_NPC);
    assign w_fetch_act = r_run && (r_state == FETCH);

    // Holds iREN low for the first cycle after reset is released
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= FETCH;
        else       r_state <= w_state_nxt;
    end

    // FSM next state and read request; halt always wins
    always_comb begin
        w_state_nxt = r_state;
        iREN        = 1'b0;
        case (r_state)
            FETCH: begin
                iREN = w_fetch_act && !w_skid_valid;
                if (halt) w_state_nxt = HALTED;
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    // Next-PC source select; only honoured when the PC is allowed to move
    always_comb begin
        w_pc_sel = r_pc;
        if (pc_enable && r_run && !w_frozen) begin
            case (pc_select)
                PC_NPC:  w_pc_sel = w_npc;
                PC_BR:   w_pc_sel = br_addr;
                PC_J:    w_pc_sel = j_addr;
                PC_JR:   w_pc_sel = jr_addr;
                default: w_pc_sel = w_npc;
            endcase
        end
    end

    // PC register, word aligned, wraps silently at 32 bits
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_pc <= word_align(PC_INIT);
        else       r_pc <= word_align(w_pc_sel);
    end

    assign imemaddr = r_pc;

`ifdef FETCH_SKID_EN
    logic [31:0] w_skid_data;
    logic [31:0] w_skid_npc;
    logic        w_skid_capture;

    assign w_skid_capture = ihit && !ifid_enable && w_fetch_act && !halt;

    fetch_skid u_skid (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_capture (w_skid_capture),
        .i_release (ifid_enable),
        .i_clear   (ifid_flush || w_redirect),
        .i_data    (imemload),
        .i_npc     (w_npc),
        .o_valid   (w_skid_valid),
        .o_data    (w_skid_data),
        .o_npc     (w_skid_npc)
    );

    // IF/ID load source: skid entry first, else the live cache word
    always_comb begin
        w_ld_ins   = 32'h0;
        w_ld_npc   = w_npc;
        w_ld_valid = 1'b0;
        if (!w_frozen) begin
            if (w_skid_valid && !w_redirect) begin
                w_ld_ins   = w_skid_data;
                w_ld_npc   = w_skid_npc;
                w_ld_valid = 1'b1;
            end else if (ihit && r_run) begin
                w_ld_ins   = imemload;
                w_ld_valid = 1'b1;
            end
        end
    end
`else
    assign w_skid_valid = 1'b0;

    // IF/ID load source: live cache word, bubble on miss or when halted
    always_comb begin
        w_ld_ins   = 32'h0;
        w_ld_npc   = w_npc;
        w_ld_valid = 1'b0;
        if (!w_frozen && ihit && r_run) begin
            w_ld_ins   = imemload;
            w_ld_valid = 1'b1;
        end
    end
`endif

    // IF/ID latch: flush beats enable, otherwise hold
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ifid_ins   <= 32'h0;
            r_ifid_npc   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (ifid_flush) begin
            r_ifid_ins   <= 32'h0;
            r_ifid_npc   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (ifid_enable) begin
            r_ifid_ins   <= w_ld_ins;
            r_ifid_npc   <= w_ld_npc;
            r_ifid_valid <= w_ld_valid;
        end
    end

    assign ifid_imemload = r_ifid_ins;
    assign ifid_npc      = r_ifid_npc;
    assign ifid_valid    = r_ifid_valid;
endmodule
`default_nettype wire
